// File: rtl/apb_sram_arb_if.sv
// rtl/apb_sram_arb_if.sv - two-master APB bundle plus shared slave-side APB bus
interface apb_sram_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel_m0, penable_m0, pwrite_m0;
  logic [ADDR_W-1:0] paddr_m0;
  logic [DATA_W-1:0] pwdata_m0, prdata_m0;
  logic              pready_m0, pslverr_m0;

  logic              psel_m1, penable_m1, pwrite_m1;
  logic [ADDR_W-1:0] paddr_m1;
  logic [DATA_W-1:0] pwdata_m1, prdata_m1;
  logic              pready_m1, pslverr_m1;

  logic              s_psel, s_penable, s_pwrite;
  logic [ADDR_W-1:0] s_paddr;
  logic [DATA_W-1:0] s_pwdata, s_prdata;
  logic              s_pready;

  // arbiter view: completer towards both masters, requester on the slave bus
  modport slave (
    input  psel_m0, penable_m0, pwrite_m0, paddr_m0, pwdata_m0,
    output prdata_m0, pready_m0, pslverr_m0,
    input  psel_m1, penable_m1, pwrite_m1, paddr_m1, pwdata_m1,
    output prdata_m1, pready_m1, pslverr_m1,
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_prdata, s_pready
  );

  // environment view: both masters and the SRAM slave
  modport master (
    output psel_m0, penable_m0, pwrite_m0, paddr_m0, pwdata_m0,
    input  prdata_m0, pready_m0, pslverr_m0,
    output psel_m1, penable_m1, pwrite_m1, paddr_m1, pwdata_m1,
    input  prdata_m1, pready_m1, pslverr_m1,
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_prdata, s_pready
  );
endinterface

// File: rtl/apb_sram_arb.sv
// rtl/apb_sram_arb.sv - round-robin 2:1 APB arbiter; optional access timeout under APB_SRAM_ARB_TIMEOUT_EN
module apb_sram_arb #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rstn,
  apb_sram_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       timeout_hit;
  logic       done;
  logic       active;
  logic       in_access;

`ifdef APB_SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == ST_ACCESS) && !bus.s_pready &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  // wait-state counter: cleared while entering ACCESS, counts stalled ACCESS cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if (state_q == ST_ACCESS && !bus.s_pready && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = bus.s_pready || timeout_hit;

  // next state, grant latch in IDLE and last-served pointer update on completion
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.psel_m0 || bus.psel_m1) begin
          state_d = ST_SETUP;
          grant_d = (bus.psel_m0 && bus.psel_m1) ? ~last_q : bus.psel_m1;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers; pointer resets to 1 so master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // outputs are masked while rstn is low so an aborted transfer never completes
  assign active    = rstn && (state_q != ST_IDLE);
  assign in_access = rstn && (state_q == ST_ACCESS);

  // slave bus: controls from state, address/data muxed from the granted master
  always_comb begin
    bus.s_psel    = active;
    bus.s_penable = in_access;
    bus.s_paddr   = '0;
    bus.s_pwrite  = 1'b0;
    bus.s_pwdata  = '0;
    if (active) begin
      if (grant_q) begin
        bus.s_paddr  = bus.paddr_m1;
        bus.s_pwrite = bus.pwrite_m1;
        bus.s_pwdata = bus.pwdata_m1;
      end else begin
        bus.s_paddr  = bus.paddr_m0;
        bus.s_pwrite = bus.pwrite_m0;
        bus.s_pwdata = bus.pwdata_m0;
      end
    end
  end

  // master responses: only the granted master sees pready; read data gated by it
  always_comb begin
    bus.pready_m0  = in_access && !grant_q && done;
    bus.pready_m1  = in_access &&  grant_q && done;
    bus.pslverr_m0 = bus.pready_m0 && timeout_hit;
    bus.pslverr_m1 = bus.pready_m1 && timeout_hit;
    bus.prdata_m0  = (bus.pready_m0 && !timeout_hit) ? bus.s_prdata : '0;
    bus.prdata_m1  = (bus.pready_m1 && !timeout_hit) ? bus.s_prdata : '0;
  end

endmodule

// File: tb/tb_apb_sram_arb.sv
// tb/tb_apb_sram_arb.sv - self-checking bench for apb_sram_arb
module tb_apb_sram_arb;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb_sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_sram_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int p0_cnt   = 0;
  int p1_cnt   = 0;

  // count completion pulses seen by each master over the previous cycle
  always @(posedge clk) begin
    if (bus.pready_m0 === 1'b1) p0_cnt++;
    if (bus.pready_m1 === 1'b1) p1_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.psel_m0 = 0; bus.penable_m0 = 0; bus.pwrite_m0 = 0; bus.paddr_m0 = '0; bus.pwdata_m0 = '0;
    bus.psel_m1 = 0; bus.penable_m1 = 0; bus.pwrite_m1 = 0; bus.paddr_m1 = '0; bus.pwdata_m1 = '0;
    bus.s_pready = 0; bus.s_prdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  // round-robin rule: sole requester wins, a tie goes to the master not served last
  function automatic int rr_pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  task automatic test_reset();
    logic [6:0] ctl;
    idle_inputs();
    bus.psel_m0 = 1; bus.psel_m1 = 1; bus.s_pready = 1; bus.s_prdata = $urandom | 32'h1;
    rstn = 0;
    tick();
    tick();
    smp();
    ctl = {bus.s_psel, bus.s_penable, bus.s_pwrite, bus.pready_m0, bus.pready_m1, bus.pslverr_m0, bus.pslverr_m1};
    checks++;
    if (ctl !== 7'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000000", ctl); end
    checks++;
    if (bus.s_paddr !== '0 || bus.s_pwdata !== '0) begin
      failures++; $display("FAIL reset_s_bus got addr=%h wdata=%h exp 0", bus.s_paddr, bus.s_pwdata);
    end
    checks++;
    if (bus.prdata_m0 !== '0 || bus.prdata_m1 !== '0) begin
      failures++; $display("FAIL reset_prdata got %h/%h exp 0", bus.prdata_m0, bus.prdata_m1);
    end
    idle_inputs();
    rstn = 1;
    tick();
    smp();
    checks++;
    if (bus.s_psel !== 1'b0) begin failures++; $display("FAIL reset_idle_hold s_psel got=%b exp=0", bus.s_psel); end
  endtask

  task automatic test_single_write();
    p0_cnt = 0; p1_cnt = 0;
    tick();
    bus.psel_m0 = 1; bus.pwrite_m0 = 1; bus.paddr_m0 = 12'h010; bus.pwdata_m0 = 32'hDEADBEEF;
    smp();
    checks++;
    if (bus.s_psel !== 1'b0) begin failures++; $display("FAIL wr_idle_cycle s_psel got=%b exp=0", bus.s_psel); end
    tick();
    bus.penable_m0 = 1;
    smp();
    checks++;
    if ({bus.s_psel, bus.s_penable, bus.s_pwrite} !== 3'b101 || bus.s_paddr !== 12'h010 || bus.s_pwdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_setup got psel/pen/pwr=%b%b%b addr=%h data=%h exp 101 010 deadbeef",
               bus.s_psel, bus.s_penable, bus.s_pwrite, bus.s_paddr, bus.s_pwdata);
    end
    tick();
    bus.s_pready = 1;
    smp();
    checks++;
    if ({bus.s_penable, bus.pready_m0, bus.pready_m1, bus.pslverr_m0} !== 4'b1100) begin
      failures++;
      $display("FAIL wr_access got pen/rdy0/rdy1/err0=%b%b%b%b exp 1100",
               bus.s_penable, bus.pready_m0, bus.pready_m1, bus.pslverr_m0);
    end
    tick();
    idle_inputs();
    smp();
    checks++;
    if (bus.s_psel !== 1'b0) begin failures++; $display("FAIL wr_return_idle s_psel got=%b exp=0", bus.s_psel); end
    tick();
    smp();
    checks++;
    if (p0_cnt !== 1 || p1_cnt !== 0) begin
      failures++; $display("FAIL wr_pulse_count got p0=%0d p1=%0d exp p0=1 p1=0", p0_cnt, p1_cnt);
    end
  endtask

  task automatic test_single_read();
    tick();
    bus.psel_m1 = 1; bus.pwrite_m1 = 0; bus.paddr_m1 = 12'h010; bus.s_prdata = 32'hDEADBEEF;
    smp();
    checks++;
    if (bus.prdata_m1 !== '0) begin failures++; $display("FAIL rd_idle prdata_m1 got=%h exp=0", bus.prdata_m1); end
    tick();
    smp();
    checks++;
    if (bus.s_paddr !== 12'h010 || bus.s_pwrite !== 1'b0) begin
      failures++; $display("FAIL rd_setup got addr=%h pwrite=%b exp 010 0", bus.s_paddr, bus.s_pwrite);
    end
    tick();
    smp();
    checks++;
    if (bus.pready_m1 !== 1'b0 || bus.prdata_m1 !== '0) begin
      failures++; $display("FAIL rd_wait got rdy1=%b prdata=%h exp 0 0", bus.pready_m1, bus.prdata_m1);
    end
    tick();
    bus.s_pready = 1;
    smp();
    checks++;
    if (bus.pready_m1 !== 1'b1 || bus.prdata_m1 !== 32'hDEADBEEF || bus.prdata_m0 !== '0) begin
      failures++;
      $display("FAIL rd_done got rdy1=%b prdata_m1=%h prdata_m0=%h exp 1 deadbeef 0",
               bus.pready_m1, bus.prdata_m1, bus.prdata_m0);
    end
    tick();
    bus.psel_m1 = 0; bus.s_pready = 0;
    smp();
    checks++;
    if (bus.prdata_m1 !== '0) begin failures++; $display("FAIL rd_after prdata_m1 got=%h exp=0", bus.prdata_m1); end
    idle_inputs();
  endtask

  // both masters issue n transfers each from reset; model tracks owner, gaps and data
  task automatic test_contention(input int n, input string tag);
    logic [AW-1:0] ta[2][8];
    logic [DW-1:0] td[2][8];
    logic          tw[2][8];
    logic [DW-1:0] rd_now;
    int idx[2];
    int served[$];
    int model_last = 1;
    int owner = -1;
    int idle_run = 0;
    int viol = 0;
    int cyc = 0;
    int got;
    bit r0 = 0, r1 = 0;
    bit prev_psel = 0;
    bit started = 0;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 8; k++) begin
        ta[m][k] = AW'($urandom);
        td[m][k] = $urandom;
        tw[m][k] = 1'($urandom_range(0, 1));
      end
    end
    idx[0] = 0; idx[1] = 0;
    while ((idx[0] < n || idx[1] < n) && cyc < 400) begin
      tick();
      bus.psel_m0 = (idx[0] < n); bus.penable_m0 = bus.psel_m0;
      if (idx[0] < n) begin bus.paddr_m0 = ta[0][idx[0]]; bus.pwdata_m0 = td[0][idx[0]]; bus.pwrite_m0 = tw[0][idx[0]]; end
      bus.psel_m1 = (idx[1] < n); bus.penable_m1 = bus.psel_m1;
      if (idx[1] < n) begin bus.paddr_m1 = ta[1][idx[1]]; bus.pwdata_m1 = td[1][idx[1]]; bus.pwrite_m1 = tw[1][idx[1]]; end
      rd_now = $urandom;
      bus.s_prdata = rd_now;
      bus.s_pready = 1'($urandom_range(0, 1));
      smp();
      if (!bus.s_psel) begin
        r0 = bus.psel_m0; r1 = bus.psel_m1;
        idle_run++;
      end else if (!prev_psel) begin
        owner = rr_pick(r0, r1, model_last);
        checks++;
        if (bus.s_paddr !== ta[owner][idx[owner]] || bus.s_pwdata !== td[owner][idx[owner]] || bus.s_pwrite !== tw[owner][idx[owner]]) begin
          failures++;
          $display("FAIL %s_setup_fields got addr=%h data=%h wr=%b exp addr=%h data=%h wr=%b (master %0d)", tag,
                   bus.s_paddr, bus.s_pwdata, bus.s_pwrite, ta[owner][idx[owner]], td[owner][idx[owner]], tw[owner][idx[owner]], owner);
        end
        if (started) begin
          checks++;
          if (idle_run !== 1) begin failures++; $display("FAIL %s_idle_gap got=%0d exp=1", tag, idle_run); end
        end
        started = 1;
        idle_run = 0;
      end
      if (bus.s_psel && owner >= 0 && ((owner == 0) ? bus.pready_m1 : bus.pready_m0)) viol++;
      if (bus.pready_m0 || bus.pready_m1) begin
        got = bus.pready_m1 ? 1 : 0;
        checks++;
        if (got !== owner || (bus.pready_m0 && bus.pready_m1)) begin
          failures++; $display("FAIL %s_owner got rdy0=%b rdy1=%b exp master %0d", tag, bus.pready_m0, bus.pready_m1, owner);
        end
        checks++;
        if ((got ? bus.prdata_m1 : bus.prdata_m0) !== rd_now) begin
          failures++; $display("FAIL %s_prdata got=%h exp=%h", tag, got ? bus.prdata_m1 : bus.prdata_m0, rd_now);
        end
        served.push_back(owner);
        model_last = owner;
        if (owner >= 0 && owner < 2) idx[owner]++;
      end
      prev_psel = bus.s_psel;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (cyc >= 400) begin failures++; $display("FAIL %s_budget got cycles=%0d exp <400", tag, cyc); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL %s_nongranted_pready got=%0d exp=0", tag, viol); end
    checks++;
    if (served.size() !== 2 * n) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, served.size(), 2 * n); end
    for (int k = 0; k < served.size(); k++) begin
      checks++;
      if (served[k] !== (k % 2)) begin failures++; $display("FAIL %s_order[%0d] got=%0d exp=%0d", tag, k, served[k], k % 2); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    a0 = AW'($urandom); a1 = ~a0;
    do_reset();
    bus.psel_m0 = 1; bus.paddr_m0 = a0;
    tick();
    tick();
    bus.s_pready = 1;
    tick();
    idle_inputs();
    tick();
    bus.psel_m1 = 1; bus.paddr_m1 = a1;
    tick();
    tick();
    smp();
    checks++;
    if (bus.s_penable !== 1'b1) begin failures++; $display("FAIL rst_mid_in_access s_penable got=%b exp=1", bus.s_penable); end
    p0_cnt = 0; p1_cnt = 0;
    tick();
    rstn = 0;
    smp();
    checks++;
    if ({bus.s_psel, bus.s_penable, bus.pready_m0, bus.pready_m1} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_during got psel/pen/rdy0/rdy1=%b%b%b%b exp 0000",
                           bus.s_psel, bus.s_penable, bus.pready_m0, bus.pready_m1);
    end
    tick();
    rstn = 1;
    idle_inputs();
    smp();
    checks++;
    if ({bus.s_psel, bus.s_penable, bus.pready_m0, bus.pready_m1} !== 4'b0 || bus.s_paddr !== '0) begin
      failures++; $display("FAIL rst_mid_after got psel/pen/rdy0/rdy1=%b%b%b%b addr=%h exp 0",
                           bus.s_psel, bus.s_penable, bus.pready_m0, bus.pready_m1, bus.s_paddr);
    end
    tick();
    bus.psel_m0 = 1; bus.paddr_m0 = a0;
    bus.psel_m1 = 1; bus.paddr_m1 = a1;
    tick();
    smp();
    checks++;
    if (bus.s_paddr !== a0) begin failures++; $display("FAIL rst_mid_tie_ptr got addr=%h exp=%h (master 0)", bus.s_paddr, a0); end
    tick();
    bus.s_pready = 1;
    smp();
    checks++;
    if (bus.pready_m0 !== 1'b1) begin failures++; $display("FAIL rst_mid_tie_done pready_m0 got=%b exp=1", bus.pready_m0); end
    tick();
    idle_inputs();
    tick();
    smp();
    checks++;
    if (p1_cnt !== 0) begin failures++; $display("FAIL rst_mid_no_pulse p1 got=%0d exp=0", p1_cnt); end
  endtask

  task automatic test_timeout();
    int stall = 0;
    do_reset();
    bus.psel_m0 = 1; bus.pwrite_m0 = 0; bus.paddr_m0 = AW'($urandom);
    bus.s_prdata = $urandom | 32'h1;
    tick();
`ifdef APB_SRAM_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      tick();
      smp();
      if (k < TO) begin
        checks++;
        if (bus.pready_m0 !== 1'b0) begin failures++; $display("FAIL to_early[%0d] pready_m0 got=%b exp=0", k, bus.pready_m0); end
      end else begin
        checks++;
        if ({bus.pready_m0, bus.pslverr_m0} !== 2'b11 || bus.prdata_m0 !== '0) begin
          failures++; $display("FAIL to_fire got rdy/err=%b%b prdata=%h exp 11 0", bus.pready_m0, bus.pslverr_m0, bus.prdata_m0);
        end
      end
    end
    tick();
    idle_inputs();
    smp();
    checks++;
    if (bus.s_psel !== 1'b0) begin failures++; $display("FAIL to_idle s_psel got=%b exp=0", bus.s_psel); end
`else
    tick();
    for (int k = 0; k < 120; k++) begin
      tick();
      smp();
      if (bus.s_penable && !bus.pready_m0 && !bus.pslverr_m0) stall++;
    end
    checks++;
    if (stall !== 120) begin failures++; $display("FAIL to_persist got=%0d exp=120", stall); end
    tick();
    bus.s_pready = 1;
    smp();
    checks++;
    if ({bus.pready_m0, bus.pslverr_m0} !== 2'b10) begin
      failures++; $display("FAIL to_late_done got rdy/err=%b%b exp 10", bus.pready_m0, bus.pslverr_m0);
    end
    tick();
    idle_inputs();
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    do_reset();
    test_contention(1, "tie");
    do_reset();
    test_contention(4, "b2b");
    test_reset_mid_access();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_sram_arb.md
APB_SRAM_ARB -- requirements
Module: apb_sram_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the access-phase cycle limit used when the timeout feature is compiled in.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock, all state updates on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- psel_m0, penable_m0, pwrite_m0  in  1 each  master 0 APB controls.
- paddr_m0  in  ADDR_W  master 0 address.
- pwdata_m0  in  DATA_W  master 0 write data.
- prdata_m0  out  DATA_W  master 0 read data.
- pready_m0, pslverr_m0  out  1 each  master 0 completion and error.
- psel_m1 .. pslverr_m1  SHALL be identical to the master 0 set, for master 1.
- s_psel, s_penable, s_pwrite  out  1 each  slave APB controls.
- s_paddr  out  ADDR_W  slave address.
- s_pwdata  out  DATA_W  slave write data.
- s_prdata  in  DATA_W  slave read data.
- s_pready  in  1  slave completion.

Function
REQ-005 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-006 A master SHALL be requesting while its psel_mX=1.
REQ-007 In IDLE with at least one master requesting, the block SHALL latch the grant and go to SETUP on the next edge; with no request it SHALL stay in IDLE.
REQ-008 Arbitration SHALL be round-robin.
- A sole requester SHALL win.
- When both masters request, the master not served last SHALL win.
- After reset, the pointer SHALL be "last=1", so master 0 wins the first tie.
REQ-009 In SETUP, the outputs SHALL be s_psel=1 and s_penable=0; the next state SHALL be ACCESS unconditionally.
REQ-010 In ACCESS, the outputs SHALL be s_psel=1 and s_penable=1; the block SHALL stay in ACCESS until s_pready=1 and then go to IDLE, updating the last-served pointer to the granted master.
REQ-011 In SETUP and ACCESS, s_paddr, s_pwrite and s_pwdata SHALL be driven combinationally from the granted master's inputs; in IDLE they SHALL be 0.
REQ-012 pready_mX SHALL equal (state==ACCESS && grant==X && s_pready), combinationally.
REQ-013 prdata_mX SHALL equal s_prdata when pready_mX=1, else 0.
REQ-014 The non-granted master's pready SHALL remain 0, so its transfer is stalled, not dropped.
REQ-015 Minimum transfer latency SHALL be 3 cycles from IDLE with psel_mX=1 to completion: IDLE, SETUP, then ACCESS with s_pready=1.
REQ-016 Every completion SHALL return through IDLE for at least one cycle, so slave transfers are never back-to-back without an IDLE cycle.
REQ-017 Once granted, the grant SHALL be held until completion, even if the granted master deasserts psel, which is a protocol violation.
REQ-018 A request arriving from either master while not in IDLE SHALL only be considered at the next IDLE cycle.

Reset
REQ-019 While rstn=0 at a rising edge, the next state SHALL be IDLE, the grant 0 and the last-served pointer 1.
REQ-020 Reset SHALL produce these outputs: all s_* outputs 0, and pready_mX, pslverr_mX and prdata_mX all 0.
REQ-021 The timeout counter, if present, SHALL reset to 0.
REQ-022 Reset asserted in SETUP or ACCESS SHALL abort the transfer with no pready pulse to either master.

Configuration
REQ-023 With macro APB_SRAM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with s_pready=0.
REQ-024 With APB_SRAM_ARB_TIMEOUT_EN defined, on the cycle the counter equals TIMEOUT-1 with s_pready=0, the granted master SHALL get pready_mX=1, pslverr_mX=1 and prdata_mX=0; the FSM SHALL then go to IDLE and update the pointer.
REQ-025 Without APB_SRAM_ARB_TIMEOUT_EN, no counter SHALL exist, pslverr_m0 and pslverr_m1 SHALL be tied 0, and ACCESS SHALL wait indefinitely.

Verification
REQ-026 Single write, with master 0 writing paddr=0x010 and pwdata=0xDEADBEEF, slave pready one cycle into ACCESS: s_psel SHALL rise one cycle after the request, pready_m0 SHALL pulse once, and master 1 SHALL see no activity.
REQ-027 Single read, with master 1 reading 0x010 and s_prdata=0xDEADBEEF on pready: prdata_m1 SHALL be 0xDEADBEEF in the pready_m1 cycle and 0 in other cycles.
REQ-028 Tie after reset, with both masters requesting in the same cycle: master 0 SHALL be served first, then master 1, with pready_m1 held 0 throughout master 0's transfer.
REQ-029 Continuous contention, with both masters issuing 4 back-to-back transfers: grants SHALL alternate 0,1,0,1,..., with exactly one IDLE cycle between slave transfers.
REQ-030 Reset mid-ACCESS, with rstn=0 for one cycle while s_pready=0: on the next cycle the FSM SHALL be in IDLE, all outputs 0, no pready pulse, and the tie pointer SHALL be reset.
REQ-031 Timeout, with APB_SRAM_ARB_TIMEOUT_EN defined, TIMEOUT=4 and s_pready held 0: pready_m0 and pslverr_m0 SHALL be 1 in the 4th ACCESS cycle; without the macro, ACCESS SHALL persist for more than 100 cycles.
